// File: rtl/col_fetch_pkg.sv
// Shared types and widths for the column-interleaved page fetch scheduler.
// Optional statistics counters are enabled with COL_FETCH_STATS_EN.
package col_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  localparam int unsigned PageWordsW = 8;
  localparam int unsigned PageCountW = 16;
  localparam int unsigned StatsW     = 32;

  // Saturating increment so long runs pin at all-ones instead of wrapping.
  function automatic logic [StatsW-1:0] sat_inc(input logic [StatsW-1:0] v);
    return (&v) ? v : v + StatsW'(1);
  endfunction

endpackage

// File: rtl/col_fetch_rsp_tracker.sv
// Counts forwarded words within the current page and flags the last word of each page.
module col_fetch_rsp_tracker
  import col_fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  hs_i,
  input  logic [PageWordsW-1:0] page_words_i,
  output logic                  last_o
);

  logic [PageWordsW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == page_words_i - PageWordsW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hs_i) begin
      cnt_d = last_o ? '0 : cnt_q + PageWordsW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/col_fetch_scheduler.sv
// Issues page reads column-interleaved per row group and forwards read data with page framing.
// Define COL_FETCH_STATS_EN to build the issued-page and stall counters.
module col_fetch_scheduler
  import col_fetch_pkg::*;
#(
  parameter int unsigned COL_COUNT       = 3,
  parameter int unsigned MEMORY_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [COL_COUNT*ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [PageWordsW-1:0]           cmd_page_words,
  input  logic [PageCountW-1:0]           cmd_page_count,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,

  output logic [ADDR_WIDTH-1:0]           rd_cmd_addr,
  output logic [PageWordsW-1:0]           rd_cmd_len,
  output logic                            rd_cmd_valid,
  input  logic                            rd_cmd_ready,

  input  logic [MEMORY_WIDTH-1:0]         rd_data,
  input  logic                            rd_data_valid,
  output logic                            rd_data_ready,

  output logic [MEMORY_WIDTH-1:0]         out_data,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready,

  output logic                            busy,
  output logic                            done,
  output logic [StatsW-1:0]               stat_pages,
  output logic [StatsW-1:0]               stat_stall
);

  localparam int unsigned ColPtrW = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
  localparam int unsigned OutW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OffW    = PageCountW + PageWordsW;

  state_e                          state_q, state_d;
  logic [COL_COUNT*ADDR_WIDTH-1:0] base_q, base_d;
  logic [PageWordsW-1:0]           page_words_q, page_words_d;
  logic [PageCountW-1:0]           page_count_q, page_count_d;
  logic [ColPtrW-1:0]              col_ptr_q, col_ptr_d;
  logic [PageCountW-1:0]           page_idx_q, page_idx_d;
  logic [OutW-1:0]                 outstanding_q, outstanding_d;

  logic                  active;
  logic                  cmd_hs;
  logic                  rd_cmd_hs;
  logic                  out_hs;
  logic                  retire;
  logic                  last_col;
  logic                  last_page;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [OffW-1:0]       offset;

  assign active    = (state_q != StIdle);
  assign cmd_ready = rst && (state_q == StIdle);
  assign busy      = active;
  assign done      = (state_q == StDrain) && (outstanding_q == '0);

  assign rd_cmd_valid = (state_q == StIssue) && (outstanding_q < OutW'(MAX_OUTSTANDING));
  assign base_sel     = base_q[col_ptr_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign offset       = {{PageWordsW{1'b0}}, page_idx_q} * {{PageCountW{1'b0}}, page_words_q};
  assign rd_cmd_addr  = base_sel + ADDR_WIDTH'(offset);
  assign rd_cmd_len   = page_words_q;

  // Data is never accepted in IDLE so stale responses cannot corrupt page framing.
  assign out_data      = rd_data;
  assign out_valid     = rd_data_valid && active;
  assign rd_data_ready = out_ready && active;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign rd_cmd_hs = rd_cmd_valid && rd_cmd_ready;
  assign out_hs    = out_valid && out_ready;
  assign retire    = out_hs && out_last;
  assign last_col  = (col_ptr_q == ColPtrW'(COL_COUNT - 1));
  assign last_page = (page_idx_q == page_count_q - PageCountW'(1));

  col_fetch_rsp_tracker u_rsp_tracker (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (cmd_hs),
    .hs_i         (out_hs),
    .page_words_i (page_words_q),
    .last_o       (out_last)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    page_words_d = page_words_q;
    page_count_d = page_count_q;
    col_ptr_d    = col_ptr_q;
    page_idx_d   = page_idx_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          base_d       = cmd_base_addr;
          page_words_d = cmd_page_words;
          page_count_d = cmd_page_count;
          col_ptr_d    = '0;
          page_idx_d   = '0;
          // Empty commands skip straight to DRAIN, which completes on the next cycle.
          if ((cmd_page_count == '0) || (cmd_page_words == '0)) begin
            state_d = StDrain;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (rd_cmd_hs) begin
          if (last_col) begin
            col_ptr_d  = '0;
            page_idx_d = page_idx_q + PageCountW'(1);
            if (last_page) begin
              state_d = StDrain;
            end
          end else begin
            col_ptr_d = col_ptr_q + ColPtrW'(1);
          end
        end
      end
      StDrain: begin
        if (outstanding_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({rd_cmd_hs, retire})
      2'b10:   outstanding_d = outstanding_q + OutW'(1);
      2'b01:   outstanding_d = outstanding_q - OutW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      base_q        <= '0;
      page_words_q  <= '0;
      page_count_q  <= '0;
      col_ptr_q     <= '0;
      page_idx_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      page_words_q  <= page_words_d;
      page_count_q  <= page_count_d;
      col_ptr_q     <= col_ptr_d;
      page_idx_q    <= page_idx_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef COL_FETCH_STATS_EN
  logic [StatsW-1:0] stat_pages_q, stat_pages_d;
  logic [StatsW-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_pages_d = stat_pages_q;
    stat_stall_d = stat_stall_q;
    if (cmd_hs) begin
      stat_pages_d = '0;
      stat_stall_d = '0;
    end else begin
      if (rd_cmd_hs) begin
        stat_pages_d = sat_inc(stat_pages_q);
      end
      if ((state_q == StIssue) && (outstanding_q == OutW'(MAX_OUTSTANDING))) begin
        stat_stall_d = sat_inc(stat_stall_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pages_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_pages_q <= stat_pages_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_pages = stat_pages_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_pages = '0;
  assign stat_stall = '0;
`endif

endmodule
